// File: rtl/hazard_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_mc_if
//  Purpose  : Bundle of the decode-stage fields consumed by the hazard
//             controller and the stall/flush/forward controls it returns.
//  Ports    : RAD/SrcValidD/WA3D/RegWriteD/MemtoRegD/MultiCycleD/BranchTakenE
//             flow datapath -> controller; ForwardE/Stall*/Flush* flow back.
//             modport master = datapath side, modport slave = controller.
//  Revision : 1.0  initial release
// ============================================================================
interface hazard_ctrl_mc_if #(
   parameter int AW      = 4,
   parameter int NUM_SRC = 3
);
   logic [NUM_SRC*AW-1:0] RAD;
   logic [NUM_SRC-1:0]    SrcValidD;
   logic [AW-1:0]         WA3D;
   logic                  RegWriteD;
   logic                  MemtoRegD;
   logic                  MultiCycleD;
   logic                  BranchTakenE;
   logic [NUM_SRC*2-1:0]  ForwardE;
   logic                  StallF;
   logic                  StallD;
   logic                  StallE;
   logic                  FlushD;
   logic                  FlushE;

   modport master (
      output RAD, SrcValidD, WA3D, RegWriteD, MemtoRegD, MultiCycleD, BranchTakenE,
      input  ForwardE, StallF, StallD, StallE, FlushD, FlushE
   );

   modport slave (
      input  RAD, SrcValidD, WA3D, RegWriteD, MemtoRegD, MultiCycleD, BranchTakenE,
      output ForwardE, StallF, StallD, StallE, FlushD, FlushE
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_mc
//  Purpose  : Hazard and forwarding controller for the 5-stage core. Keeps a
//             private E/M/W scoreboard and produces forwarding selects for
//             NUM_SRC operands, load-use stalls, multi-cycle execute stalls
//             and branch flushes.
//  Ports    : clk   - clock, rising edge
//             reset - asynchronous, active-high
//             hz    - hazard_ctrl_mc_if.slave (decode fields in, controls out)
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_mc #(
   parameter int AW      = 4,
   parameter int NUM_SRC = 3,
   parameter int MC_LAT  = 3
) (
   input  wire logic         clk,
   input  wire logic         reset,
   hazard_ctrl_mc_if.slave   hz
);
   localparam int            CW          = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
   localparam logic [AW-1:0] c_pc_addr   = '1;
   // With MC_LAT = 1 this is zero, so a multi-cycle op never loads the counter.
   localparam logic [CW-1:0] c_mc_init   = CW'(MC_LAT - 1);

   // E stage scoreboard
   logic                  e_valid_q, e_valid_d;
   logic [AW-1:0]         e_wa_q,    e_wa_d;
   logic                  e_rw_q,    e_rw_d;
   logic                  e_mtr_q,   e_mtr_d;
   logic [NUM_SRC*AW-1:0] e_ra_q,    e_ra_d;
   logic [NUM_SRC-1:0]    e_srcv_q,  e_srcv_d;
   // M and W stage scoreboard (load flag is only ever consulted in E)
   logic                  m_valid_q, m_valid_d;
   logic [AW-1:0]         m_wa_q,    m_wa_d;
   logic                  m_rw_q,    m_rw_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [AW-1:0]         wb_wa_q,   wb_wa_d;
   logic                  wb_rw_q,   wb_rw_d;
   // Remaining extra cycles the op in E must stay there
   logic [CW-1:0]         mc_cnt_q,  mc_cnt_d;

   logic w_mc_busy, w_branch, w_load_use;
   logic w_stall_f, w_stall_d, w_stall_e, w_flush_d, w_flush_e;
   logic [NUM_SRC*2-1:0] w_fwd;

   // Hazard detection and control priority: busy > branch > load-use
   always_comb begin
      logic [AW-1:0] ra;
      w_mc_busy  = (mc_cnt_q != '0);
      // A branch outcome is only meaningful once the op in E is complete.
      w_branch   = hz.BranchTakenE & e_valid_q & ~w_mc_busy;
      w_load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ra = hz.RAD[i*AW +: AW];
         if (e_valid_q && e_mtr_q && e_rw_q && hz.SrcValidD[i] &&
             (ra == e_wa_q) && (ra != c_pc_addr))
            w_load_use = 1'b1;
      end

      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_stall_e = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      if (w_mc_busy) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_stall_e = 1'b1;
      end else if (w_branch) begin
         w_flush_d = 1'b1;
         w_flush_e = 1'b1;
      end else if (w_load_use) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_flush_e = 1'b1;
      end
   end

   // Forwarding selects, M result preferred over W
   always_comb begin
      logic [AW-1:0] ra;
      w_fwd = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ra = e_ra_q[i*AW +: AW];
         if (e_srcv_q[i] && (ra != c_pc_addr)) begin
            if (m_valid_q && m_rw_q && (m_wa_q == ra))
               w_fwd[i*2 +: 2] = 2'b10;
            else if (wb_valid_q && wb_rw_q && (wb_wa_q == ra))
               w_fwd[i*2 +: 2] = 2'b01;
         end
      end
   end

   // Pipeline advance
   always_comb begin
      wb_valid_d = m_valid_q;
      wb_wa_d    = m_wa_q;
      wb_rw_d    = m_rw_q;

      // A stalled E sends bubbles downstream so M/W drain during the stall.
      m_valid_d  = w_stall_e ? 1'b0 : e_valid_q;
      m_wa_d     = w_stall_e ? '0   : e_wa_q;
      m_rw_d     = w_stall_e ? 1'b0 : e_rw_q;

      e_valid_d  = e_valid_q;
      e_wa_d     = e_wa_q;
      e_rw_d     = e_rw_q;
      e_mtr_d    = e_mtr_q;
      e_ra_d     = e_ra_q;
      e_srcv_d   = e_srcv_q;
      mc_cnt_d   = '0;

      if (w_mc_busy) begin
         mc_cnt_d = mc_cnt_q - 1'b1;
      end else if (w_flush_e) begin
         e_valid_d = 1'b0;
         e_wa_d    = '0;
         e_rw_d    = 1'b0;
         e_mtr_d   = 1'b0;
         e_ra_d    = '0;
         e_srcv_d  = '0;
      end else begin
         e_valid_d = 1'b1;
         e_wa_d    = hz.WA3D;
         e_rw_d    = hz.RegWriteD;
         e_mtr_d   = hz.MemtoRegD;
         e_ra_d    = hz.RAD;
         e_srcv_d  = hz.SrcValidD;
         if (hz.MultiCycleD)
            mc_cnt_d = c_mc_init;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_valid_q  <= 1'b0;
         e_wa_q     <= '0;
         e_rw_q     <= 1'b0;
         e_mtr_q    <= 1'b0;
         e_ra_q     <= '0;
         e_srcv_q   <= '0;
         m_valid_q  <= 1'b0;
         m_wa_q     <= '0;
         m_rw_q     <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_wa_q    <= '0;
         wb_rw_q    <= 1'b0;
         mc_cnt_q   <= '0;
      end else begin
         e_valid_q  <= e_valid_d;
         e_wa_q     <= e_wa_d;
         e_rw_q     <= e_rw_d;
         e_mtr_q    <= e_mtr_d;
         e_ra_q     <= e_ra_d;
         e_srcv_q   <= e_srcv_d;
         m_valid_q  <= m_valid_d;
         m_wa_q     <= m_wa_d;
         m_rw_q     <= m_rw_d;
         wb_valid_q <= wb_valid_d;
         wb_wa_q    <= wb_wa_d;
         wb_rw_q    <= wb_rw_d;
         mc_cnt_q   <= mc_cnt_d;
      end
   end

   assign hz.ForwardE = w_fwd;
   assign hz.StallF   = w_stall_f;
   assign hz.StallD   = w_stall_d;
   assign hz.StallE   = w_stall_e;
   assign hz.FlushD   = w_flush_d;
   assign hz.FlushE   = w_flush_e;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_mc
//  Purpose  : Directed testbench for hazard_ctrl_mc with a scoreboard queue.
//             The driver applies one decode-stage vector per cycle and queues
//             the hand-computed response; the monitor compares each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_mc;
   localparam logic [3:0] F_NONE = 4'b0000;  // {rw, mtr, mc, br}
   localparam logic [3:0] F_RW   = 4'b1000;
   localparam logic [3:0] F_LD   = 4'b1100;
   localparam logic [3:0] F_MC   = 4'b1010;
   localparam logic [3:0] F_BR   = 4'b0001;
   localparam logic [3:0] F_RWBR = 4'b1001;

   // {StallF, StallD, StallE, FlushD, FlushE}
   localparam logic [4:0] C_NONE = 5'b00000;
   localparam logic [4:0] C_MC   = 5'b11100;
   localparam logic [4:0] C_LU   = 5'b11001;
   localparam logic [4:0] C_BR   = 5'b00011;

   typedef struct {
      logic [10:0] exp;
      string       nm;
   } exp_t;

   logic clk;
   logic reset;
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   hazard_ctrl_mc_if #(.AW(4), .NUM_SRC(3)) hz ();

   hazard_ctrl_mc #(.AW(4), .NUM_SRC(3), .MC_LAT(3)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: every falling edge, compare the DUT against the oldest entry.
   initial begin
      exp_t        e;
      logic [10:0] act;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e   = sb.pop_front();
            act = {hz.ForwardE, hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE};
            total++;
            if (act !== e.exp) begin
               bad++;
               $display("FAIL %s: got fwd=%b ctl=%b, expected fwd=%b ctl=%b",
                        e.nm, act[10:5], act[4:0], e.exp[10:5], e.exp[4:0]);
            end
         end
      end
   end

   // rmode: 0 reset low, 1 reset high, 2 reset low then asserted mid-cycle
   task automatic step(input int rmode, input logic [11:0] rad, input logic [2:0] sv,
                       input logic [3:0] wa, input logic [3:0] fl,
                       input logic [5:0] fwd, input logic [4:0] ctl, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset           = (rmode == 1);
      hz.RAD          = rad;
      hz.SrcValidD    = sv;
      hz.WA3D         = wa;
      hz.RegWriteD    = fl[3];
      hz.MemtoRegD    = fl[2];
      hz.MultiCycleD  = fl[1];
      hz.BranchTakenE = fl[0];
      e.exp = {fwd, ctl};
      e.nm  = nm;
      sb.push_back(e);
      if (rmode == 2) begin
         #2;
         reset = 1'b1;
      end
   endtask

   initial begin
      reset           = 1'b1;
      hz.RAD          = '0;
      hz.SrcValidD    = '0;
      hz.WA3D         = '0;
      hz.RegWriteD    = 1'b0;
      hz.MemtoRegD    = 1'b0;
      hz.MultiCycleD  = 1'b0;
      hz.BranchTakenE = 1'b0;

      // Reset, including an abort in the middle of a multi-cycle op
      step(1, 12'h000, 3'b000, 4'h0, F_NONE, 6'd0,  C_NONE, "reset_hold");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd0,  C_NONE, "reset_release");
      step(0, 12'h000, 3'b000, 4'h5, F_MC,   6'd0,  C_NONE, "mul_in_d");
      step(2, 12'h000, 3'b000, 4'h0, F_NONE, 6'd0,  C_NONE, "reset_mid_mc");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd0,  C_NONE, "post_reset_no_stall");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd0,  C_NONE, "post_reset_idle");

      // Back-to-back ALU forwarding: M then W
      step(0, 12'h000, 3'b000, 4'h1, F_RW,   6'd0,  C_NONE, "add_r1");
      step(0, 12'h031, 3'b011, 4'h2, F_RW,   6'd0,  C_NONE, "sub_r2_r1_r3");
      step(0, 12'h001, 3'b001, 4'h6, F_RW,   6'd2,  C_NONE, "fwd_alum");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd1,  C_NONE, "fwd_resw");

      // Load-use on operand 2
      step(0, 12'h000, 3'b000, 4'h4, F_LD,   6'd0,  C_NONE, "ldr_r4");
      step(0, 12'h400, 3'b100, 4'h8, F_RW,   6'd0,  C_LU,   "load_use");
      step(0, 12'h400, 3'b100, 4'h8, F_RW,   6'd0,  C_NONE, "load_use_release");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd16, C_NONE, "fwd_load_w");

      // Multi-cycle MUL, MC_LAT = 3
      step(0, 12'h000, 3'b000, 4'h5, F_MC,   6'd0,  C_NONE, "mul_r5");
      step(0, 12'h005, 3'b001, 4'h9, F_RW,   6'd0,  C_MC,   "mc_stall_1");
      step(0, 12'h005, 3'b001, 4'h9, F_RW,   6'd0,  C_MC,   "mc_stall_2");
      step(0, 12'h005, 3'b001, 4'h9, F_RW,   6'd0,  C_NONE, "mc_done");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd2,  C_NONE, "fwd_after_mc");

      // Branch beats load-use; unqualified branch ignored
      step(0, 12'h000, 3'b000, 4'h4, F_LD,   6'd0,  C_NONE, "ldr_r4_b");
      step(0, 12'h400, 3'b100, 4'h8, F_RWBR, 6'd0,  C_BR,   "branch_over_lu");
      step(0, 12'h000, 3'b000, 4'h0, F_BR,   6'd0,  C_NONE, "branch_e_bubble");

      // Busy multi-cycle op masks a branch
      step(0, 12'h000, 3'b000, 4'h5, F_MC,   6'd0,  C_NONE, "mul_r5_b");
      step(0, 12'h000, 3'b000, 4'h0, F_BR,   6'd0,  C_MC,   "busy_over_branch");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd0,  C_MC,   "mc_stall_tail");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd0,  C_NONE, "mc_tail_done");

      // PC address and SrcValidD masking
      step(0, 12'h000, 3'b000, 4'hF, F_LD,   6'd0,  C_NONE, "ldr_pc");
      step(0, 12'h00F, 3'b001, 4'h3, F_RW,   6'd0,  C_NONE, "pc_no_stall");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd0,  C_NONE, "pc_no_fwd");
      step(0, 12'h000, 3'b000, 4'h4, F_LD,   6'd0,  C_NONE, "ldr_r4_c");
      step(0, 12'h044, 3'b000, 4'h3, F_RW,   6'd0,  C_NONE, "srcv_no_stall");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd0,  C_NONE, "srcv_no_fwd");

      // M result wins over W for the same register
      step(0, 12'h000, 3'b000, 4'h7, F_RW,   6'd0,  C_NONE, "add_r7_a");
      step(0, 12'h000, 3'b000, 4'h7, F_RW,   6'd0,  C_NONE, "add_r7_b");
      step(0, 12'h070, 3'b010, 4'h3, F_RW,   6'd0,  C_NONE, "read_r7");
      step(0, 12'h000, 3'b000, 4'h0, F_NONE, 6'd8,  C_NONE, "fwd_m_over_w");

      for (int k = 0; k < 20 && sb.size() != 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
